// File: rtl/birukee_pkg.sv
// Shared types and helpers for the birukee input-load stage.
package birukee_pkg;

  localparam int         BEAT_W      = 64;
  localparam logic [2:0] DMA_SIZE_64 = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    DATA_A,
    REQ_B,
    DATA_B,
    DONE
  } load_state_t;

  // Number of 64-bit beats needed to carry n 32-bit words.
  function automatic logic [31:0] beat_count(input logic [31:0] n);
    return {1'b0, n[31:1]} + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/birukee_beat_unpack.sv
// One-beat buffer that splits a 64-bit DMA beat into two registered words.
// Word order inside a beat is selected by BIRUKEE_LOAD_HIGH_FIRST_EN.
module birukee_beat_unpack
  import birukee_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              odd_tail,
  input  logic              beat_valid,
  output logic              beat_ready,
  input  logic [BEAT_W-1:0] beat_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_fire
);

  logic              valid_reg, valid_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic [WORD_W-1:0] hold_reg, hold_next;
  logic              half_reg, half_next;
  logic              single_reg, single_next;
  logic [WORD_W-1:0] first_half;
  logic [WORD_W-1:0] second_half;
  logic              last_word;
  logic              take;

`ifdef BIRUKEE_LOAD_HIGH_FIRST_EN
  assign first_half  = beat_data[BEAT_W-1:WORD_W];
  assign second_half = beat_data[WORD_W-1:0];
`else
  assign first_half  = beat_data[WORD_W-1:0];
  assign second_half = beat_data[BEAT_W-1:WORD_W];
`endif

  // A new beat may land in the same cycle the final word of the old one leaves.
  assign last_word  = valid_reg && (half_reg || single_reg);
  assign beat_ready = en && (!valid_reg || (last_word && word_ready));
  assign take       = beat_ready && beat_valid;
  assign word_fire  = valid_reg && word_ready;
  assign word_valid = valid_reg;
  assign word_data  = data_reg;

  always_comb begin
    valid_next  = valid_reg;
    data_next   = data_reg;
    hold_next   = hold_reg;
    half_next   = half_reg;
    single_next = single_reg;
    if (take) begin
      valid_next  = 1'b1;
      data_next   = first_half;
      hold_next   = second_half;
      half_next   = 1'b0;
      single_next = odd_tail;
    end else if (word_fire) begin
      if (!half_reg && !single_reg) begin
        data_next = hold_reg;
        half_next = 1'b1;
      end else begin
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      hold_reg   <= '0;
      half_reg   <= 1'b0;
      single_reg <= 1'b0;
    end else begin
      valid_reg  <= valid_next;
      data_reg   <= data_next;
      hold_reg   <= hold_next;
      half_reg   <= half_next;
      single_reg <= single_next;
    end
  end

endmodule

// File: rtl/birukee_rtl_load_ctrl.sv
// Input-load controller: two DMA read bursts (A then B) streamed as tagged words.
// Optional word order inside a beat: BIRUKEE_LOAD_HIGH_FIRST_EN (see birukee_beat_unpack).
module birukee_rtl_load_ctrl
  import birukee_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conf_done,
  input  logic [31:0]       conf_info_input1,
  input  logic [31:0]       conf_info_input2,
  output logic              dma_read_ctrl_valid,
  input  logic              dma_read_ctrl_ready,
  output logic [31:0]       dma_read_ctrl_data_index,
  output logic [31:0]       dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  input  logic              dma_read_chnl_valid,
  output logic              dma_read_chnl_ready,
  input  logic [BEAT_W-1:0] dma_read_chnl_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_sel,
  output logic              out_last,
  output logic              load_done
);

  load_state_t       state_reg, state_next;
  logic              conf_done_reg;
  logic [31:0]       n1_reg, n1_next;
  logic [31:0]       n2_reg, n2_next;
  logic              ctrl_valid_reg, ctrl_valid_next;
  logic [31:0]       ctrl_index_reg, ctrl_index_next;
  logic [31:0]       ctrl_length_reg, ctrl_length_next;
  logic [CNT_W-1:0]  beats_rem_reg, beats_rem_next;
  logic [CNT_W-1:0]  words_rem_reg, words_rem_next;
  logic              odd_reg, odd_next;

  logic [31:0]       beats_a;
  logic [31:0]       beats_b;
  logic              data_state;
  logic              unpack_en;
  logic              odd_tail;
  logic              beat_take;
  logic              word_fire;
  logic              ctrl_fire;
  logic              last_fire;

  assign beats_a    = beat_count(n1_reg);
  assign beats_b    = beat_count(n2_reg);
  assign data_state = (state_reg == DATA_A) || (state_reg == DATA_B);
  assign unpack_en  = data_state && (beats_rem_reg != '0);
  assign odd_tail   = (beats_rem_reg == CNT_W'(1)) && odd_reg;
  assign beat_take  = dma_read_chnl_valid && dma_read_chnl_ready;
  assign ctrl_fire  = ctrl_valid_reg && dma_read_ctrl_ready;
  assign last_fire  = word_fire && (words_rem_reg == CNT_W'(1));

  birukee_beat_unpack #(
    .WORD_W (WORD_W)
  ) u_unpack (
    .clk        (clk),
    .rst        (rst),
    .en         (unpack_en),
    .odd_tail   (odd_tail),
    .beat_valid (dma_read_chnl_valid),
    .beat_ready (dma_read_chnl_ready),
    .beat_data  (dma_read_chnl_data),
    .word_valid (out_valid),
    .word_ready (out_ready),
    .word_data  (out_data),
    .word_fire  (word_fire)
  );

  always_comb begin
    state_next       = state_reg;
    n1_next          = n1_reg;
    n2_next          = n2_reg;
    ctrl_valid_next  = ctrl_valid_reg;
    ctrl_index_next  = ctrl_index_reg;
    ctrl_length_next = ctrl_length_reg;
    beats_rem_next   = beats_rem_reg;
    words_rem_next   = words_rem_reg;
    odd_next         = odd_reg;

    if (beat_take) begin
      beats_rem_next = beats_rem_reg - CNT_W'(1);
    end
    if (data_state && word_fire) begin
      words_rem_next = words_rem_reg - CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (conf_done && !conf_done_reg) begin
          n1_next    = conf_info_input1;
          n2_next    = conf_info_input2;
          state_next = REQ_A;
        end
      end
      REQ_A: begin
        if (beats_a == '0) begin
          state_next = REQ_B;
        end else if (ctrl_fire) begin
          ctrl_valid_next = 1'b0;
          beats_rem_next  = CNT_W'(beats_a);
          words_rem_next  = CNT_W'(n1_reg);
          odd_next        = n1_reg[0];
          state_next      = DATA_A;
        end else if (!ctrl_valid_reg) begin
          ctrl_valid_next  = 1'b1;
          ctrl_index_next  = '0;
          ctrl_length_next = beats_a;
        end
      end
      DATA_A: begin
        if (last_fire) begin
          state_next = REQ_B;
        end
      end
      REQ_B: begin
        if (beats_b == '0) begin
          state_next = DONE;
        end else if (ctrl_fire) begin
          ctrl_valid_next = 1'b0;
          beats_rem_next  = CNT_W'(beats_b);
          words_rem_next  = CNT_W'(n2_reg);
          odd_next        = n2_reg[0];
          state_next      = DATA_B;
        end else if (!ctrl_valid_reg) begin
          ctrl_valid_next  = 1'b1;
          ctrl_index_next  = beats_a;
          ctrl_length_next = beats_b;
        end
      end
      DATA_B: begin
        if (last_fire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      conf_done_reg   <= 1'b0;
      n1_reg          <= '0;
      n2_reg          <= '0;
      ctrl_valid_reg  <= 1'b0;
      ctrl_index_reg  <= '0;
      ctrl_length_reg <= '0;
      beats_rem_reg   <= '0;
      words_rem_reg   <= '0;
      odd_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      conf_done_reg   <= conf_done;
      n1_reg          <= n1_next;
      n2_reg          <= n2_next;
      ctrl_valid_reg  <= ctrl_valid_next;
      ctrl_index_reg  <= ctrl_index_next;
      ctrl_length_reg <= ctrl_length_next;
      beats_rem_reg   <= beats_rem_next;
      words_rem_reg   <= words_rem_next;
      odd_reg         <= odd_next;
    end
  end

  assign dma_read_ctrl_valid       = ctrl_valid_reg;
  assign dma_read_ctrl_data_index  = ctrl_index_reg;
  assign dma_read_ctrl_data_length = ctrl_length_reg;
  assign dma_read_ctrl_data_size   = DMA_SIZE_64;
  assign out_sel                   = (state_reg == DATA_B);
  assign out_last                  = out_valid && data_state && (words_rem_reg == CNT_W'(1));
  assign load_done                 = (state_reg == DONE);

endmodule

// File: tb/tb_birukee_rtl_load_ctrl.sv
// Directed bench for birukee_rtl_load_ctrl with a small DMA memory responder.
`timescale 1ns/1ps
module tb_birukee_rtl_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        conf_done = 1'b0;
  logic [31:0] conf_info_input1 = '0;
  logic [31:0] conf_info_input2 = '0;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready = 1'b0;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid = 1'b0;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sel;
  logic        out_last;
  logic        load_done;

  always #5 clk = ~clk;

  birukee_rtl_load_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .conf_done                 (conf_done),
    .conf_info_input1          (conf_info_input1),
    .conf_info_input2          (conf_info_input2),
    .dma_read_ctrl_valid       (dma_read_ctrl_valid),
    .dma_read_ctrl_ready       (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
    .dma_read_chnl_valid       (dma_read_chnl_valid),
    .dma_read_chnl_ready       (dma_read_chnl_ready),
    .dma_read_chnl_data        (dma_read_chnl_data),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready),
    .out_data                  (out_data),
    .out_sel                   (out_sel),
    .out_last                  (out_last),
    .load_done                 (load_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem_tag;
  logic [31:0] req_idx_q[$];
  logic [31:0] req_len_q[$];
  logic [31:0] wd_q[$];
  logic        wsel_q[$];
  logic        wlast_q[$];
  int done_cnt, done_iter, last_word_iter;
  int first_ctrl_iter, first_beat_iter, first_outv_iter;
  int viol_full, viol_stab, viol_ctrl, viol_early;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word_val(input int k);
    logic [15:0] lo;
    lo = k[15:0];
    return {mem_tag, 8'h00, lo};
  endfunction

  function automatic logic [63:0] mem_beat(input int i);
    return {word_val(2 * i + 1), word_val(2 * i)};
  endfunction

  // Memory word index for word j of a matrix whose burst starts at beat base.
  function automatic int exp_k(input int base, input int j);
    int beat, half;
    beat = base + j / 2;
    half = j % 2;
`ifdef BIRUKEE_LOAD_HIGH_FIRST_EN
    return 2 * beat + (1 - half);
`else
    return 2 * beat + half;
`endif
  endfunction

  task automatic run_load(input int n1, input int n2, input int out_duty, input int chnl_duty,
                          input int ctrl_stall, input int glitch_iter, input int abort_words,
                          input int budget);
    int dma_left, dma_beat, pending, stall_cnt, tail, reqs, cur_n;
    logic held_out, held_ctrl, beat_acc, ctrl_hs, beat_hs, word_hs;
    logic [31:0] held_data, held_idx, held_len;
    req_idx_q.delete(); req_len_q.delete();
    wd_q.delete(); wsel_q.delete(); wlast_q.delete();
    done_cnt = 0; done_iter = -1; last_word_iter = -1;
    first_ctrl_iter = -1; first_beat_iter = -1; first_outv_iter = -1;
    viol_full = 0; viol_stab = 0; viol_ctrl = 0; viol_early = 0;
    dma_left = 0; dma_beat = 0; pending = 0; stall_cnt = 0; tail = 0; reqs = 0; cur_n = 0;
    held_out = 1'b0; held_ctrl = 1'b0; beat_acc = 1'b0;
    held_data = '0; held_idx = '0; held_len = '0;
    conf_info_input1 = n1;
    conf_info_input2 = n2;
    for (int it = 0; it < budget; it++) begin
      @(negedge clk);
      if (held_out && (!out_valid || out_data !== held_data)) viol_stab++;
      if (held_ctrl && (!dma_read_ctrl_valid || dma_read_ctrl_data_index !== held_idx ||
                        dma_read_ctrl_data_length !== held_len)) viol_ctrl++;
      if (dma_read_ctrl_valid && first_ctrl_iter < 0) first_ctrl_iter = it;
      if (out_valid && first_outv_iter < 0) first_outv_iter = it;
      if (load_done) begin
        done_cnt++;
        if (done_iter < 0) done_iter = it;
      end
      if (done_cnt > 0) tail++;
      if (tail > 6) break;

      conf_done = (it == 0) || (it == glitch_iter);
      out_ready = ($urandom_range(99) < out_duty);
      if (dma_read_ctrl_valid && stall_cnt < ctrl_stall) begin
        dma_read_ctrl_ready = 1'b0;
        stall_cnt++;
      end else begin
        dma_read_ctrl_ready = dma_read_ctrl_valid;
      end
      if (beat_acc) dma_read_chnl_valid = 1'b0;
      if (!dma_read_chnl_valid && dma_left > 0 && $urandom_range(99) < chnl_duty) begin
        dma_read_chnl_valid = 1'b1;
        dma_read_chnl_data  = mem_beat(dma_beat);
      end

      #1;
      ctrl_hs = dma_read_ctrl_valid && dma_read_ctrl_ready;
      beat_hs = dma_read_chnl_valid && dma_read_chnl_ready;
      word_hs = out_valid && out_ready;
      if (dma_read_chnl_ready && dma_left == 0) viol_early++;
      if (beat_hs && !(pending == 0 || (pending == 1 && word_hs))) viol_full++;
      if (word_hs) begin
        wd_q.push_back(out_data);
        wsel_q.push_back(out_sel);
        wlast_q.push_back(out_last);
        last_word_iter = it;
        pending--;
      end
      if (beat_hs) begin
        pending += ((dma_left == 1) && (cur_n % 2 == 1)) ? 1 : 2;
        dma_left--;
        dma_beat++;
        if (first_beat_iter < 0) first_beat_iter = it;
      end
      beat_acc = beat_hs;
      if (ctrl_hs) begin
        req_idx_q.push_back(dma_read_ctrl_data_index);
        req_len_q.push_back(dma_read_ctrl_data_length);
        dma_left  = int'(dma_read_ctrl_data_length);
        dma_beat  = int'(dma_read_ctrl_data_index);
        cur_n     = (reqs == 0 && n1 != 0) ? n1 : n2;
        reqs++;
        stall_cnt = 0;
      end
      held_out  = out_valid && !out_ready;
      held_data = out_data;
      held_ctrl = dma_read_ctrl_valid && !dma_read_ctrl_ready;
      held_idx  = dma_read_ctrl_data_index;
      held_len  = dma_read_ctrl_data_length;
      if (abort_words > 0 && wd_q.size() >= abort_words) break;
    end
    conf_done = 1'b0;
    if (abort_words == 0) chk("load_done_seen_once", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_words(input string tag, input int n1, input int n2);
    int ba, idx;
    ba = (n1 + 1) / 2;
    chk({tag, "_word_count"}, 64'(wd_q.size()), 64'(n1 + n2));
    idx = 0;
    for (int j = 0; j < n1 + n2 && idx < wd_q.size(); j++) begin
      logic [31:0] ew;
      logic        es, el;
      if (j < n1) begin
        ew = word_val(exp_k(0, j));
        es = 1'b0;
        el = (j == n1 - 1);
      end else begin
        ew = word_val(exp_k(ba, j - n1));
        es = 1'b1;
        el = (j == n1 + n2 - 1);
      end
      chk($sformatf("%s_w%0d_data", tag, j), 64'(wd_q[idx]), 64'(ew));
      chk($sformatf("%s_w%0d_sel", tag, j), 64'(wsel_q[idx]), 64'(es));
      chk($sformatf("%s_w%0d_last", tag, j), 64'(wlast_q[idx]), 64'(el));
      $display("  %s word %0d data=%08h sel=%0d last=%0d", tag, j, wd_q[idx], wsel_q[idx], wlast_q[idx]);
      idx++;
    end
  endtask

  task automatic check_req(input string tag, input int k, input int idx, input int len);
    if (req_idx_q.size() > k) begin
      chk({tag, "_req_index"}, 64'(req_idx_q[k]), 64'(idx));
      chk({tag, "_req_length"}, 64'(req_len_q[k]), 64'(len));
      $display("  %s request %0d index=%0d length=%0d", tag, k, req_idx_q[k], req_len_q[k]);
    end else begin
      chk({tag, "_req_present"}, 64'(req_idx_q.size()), 64'(k + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl_valid"}, 64'(dma_read_ctrl_valid), 64'd0);
    chk({tag, "_ctrl_index"}, 64'(dma_read_ctrl_data_index), 64'd0);
    chk({tag, "_ctrl_length"}, 64'(dma_read_ctrl_data_length), 64'd0);
    chk({tag, "_ctrl_size"}, 64'(dma_read_ctrl_data_size), 64'd3);
    chk({tag, "_chnl_ready"}, 64'(dma_read_chnl_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_sel"}, 64'(out_sel), 64'd0);
    chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic load 4/4 with full throughput
    mem_tag = 8'h11;
    run_load(4, 4, 100, 100, 0, -1, 0, 300);
    chk("basic_req_count", 64'(req_idx_q.size()), 64'd2);
    check_req("basic_a", 0, 0, 2);
    check_req("basic_b", 1, 2, 2);
    check_words("basic", 4, 4);
    chk("basic_conf_to_ctrl_latency", 64'(first_ctrl_iter), 64'd2);
    chk("basic_beat_to_out_latency", 64'(first_outv_iter - first_beat_iter), 64'd1);
    chk("basic_violations", 64'(viol_full + viol_stab + viol_ctrl + viol_early), 64'd0);

    // Odd word counts 3/1
    mem_tag = 8'h22;
    run_load(3, 1, 100, 100, 0, -1, 0, 300);
    check_req("odd_a", 0, 0, 2);
    check_req("odd_b", 1, 2, 1);
    check_words("odd", 3, 1);
    chk("odd_violations", 64'(viol_full + viol_early), 64'd0);

    // Zero-length B
    mem_tag = 8'h33;
    run_load(5, 0, 100, 100, 0, -1, 0, 300);
    chk("zero_b_req_count", 64'(req_idx_q.size()), 64'd1);
    check_req("zero_b_a", 0, 0, 3);
    check_words("zero_b", 5, 0);
    chk("zero_b_done_after_last_word", 64'(done_iter - last_word_iter), 64'd2);

    // Backpressure with a stray conf_done edge mid-load
    mem_tag = 8'h44;
    run_load(7, 6, 30, 50, 0, 8, 0, 3000);
    chk("bp_req_count", 64'(req_idx_q.size()), 64'd2);
    check_req("bp_a", 0, 0, 4);
    check_req("bp_b", 1, 4, 3);
    check_words("bp", 7, 6);
    chk("bp_buffer_overrun", 64'(viol_full), 64'd0);
    chk("bp_out_stability", 64'(viol_stab), 64'd0);
    chk("bp_early_accept", 64'(viol_early), 64'd0);

    // Request stall: ctrl_ready low for 10 cycles on each request
    mem_tag = 8'h55;
    run_load(4, 2, 100, 100, 10, -1, 0, 500);
    check_req("stall_a", 0, 0, 2);
    check_req("stall_b", 1, 2, 1);
    check_words("stall", 4, 2);
    chk("stall_ctrl_stable", 64'(viol_ctrl), 64'd0);
    chk("stall_early_accept", 64'(viol_early), 64'd0);
    chk("stall_first_beat_iter", 64'(first_beat_iter), 64'd13);

    // Reset in the middle of DATA_A, then a clean rerun
    mem_tag = 8'h66;
    run_load(8, 4, 100, 100, 0, -1, 3, 300);
    rst = 1'b0;
    dma_read_chnl_valid = 1'b0;
    dma_read_ctrl_ready = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b1;
    @(negedge clk);
    mem_tag = 8'h77;
    run_load(8, 4, 100, 100, 0, -1, 0, 300);
    check_req("rerun_a", 0, 0, 4);
    check_req("rerun_b", 1, 4, 2);
    check_words("rerun", 8, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
